// File: rtl/fs_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and a
// constant-width helper used to size the bit counter.
package fs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/fs_serial_sub_fs.sv
// Combinational 1-bit full subtractor; the borrow-chain twin of the full-adder
// cell. Computes d = a - b - bin with borrow-out bo.
module fs (
  input  logic bin,
  input  logic a,
  input  logic b,
  output logic bo,
  output logic d
);

  assign d  = a ^ b ^ bin;
  assign bo = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/fs_serial_sub.sv
// Bit-serial subtractor: D = A - B, one bit per clock LSB first through a single
// full-subtractor cell. Define FS_OVF_EN to add the signed-overflow output Ovf.
module fs_serial_sub
  import fs_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout
`ifdef FS_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int            CW   = clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             bout_q;
  logic             bit_d, bit_bo;
  logic             accept;
  logic             last_bit;

  // A new request is only taken between operations, never mid-run.
  assign accept   = start && (state_q == IDLE || state_q == DONE);
  assign last_bit = (state_q == RUN) && (cnt_q == LAST);

  fs u_fs (
    .bin (borrow_q),
    .a   (a_q[0]),
    .b   (b_q[0]),
    .bo  (bit_bo),
    .d   (bit_d)
  );

  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: the default assignment up front keeps every path driven, so no latch
  // is inferred when a case arm leaves state_d untouched.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // Operand/partial-result shifting; D only changes on the final bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      shift_q  <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
    end else if (accept) begin
      cnt_q    <= '0;
      a_q      <= A;
      b_q      <= B;
      borrow_q <= 1'b0;
    end else if (state_q == RUN) begin
      cnt_q    <= cnt_q + CW'(1);
      a_q      <= a_q >> 1;
      b_q      <= b_q >> 1;
      borrow_q <= bit_bo;
      shift_q  <= {bit_d, shift_q[WIDTH-1:1]};
      if (last_bit) begin
        diff_q <= {bit_d, shift_q[WIDTH-1:1]};
        bout_q <= bit_bo;
      end
    end
  end

  assign D    = diff_q;
  assign Bout = bout_q;

`ifdef FS_OVF_EN
  logic sign_a_q, sign_b_q, ovf_q;

  // Overflow when operand signs differ and the result sign departs from A's.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (accept) begin
      sign_a_q <= A[WIDTH-1];
      sign_b_q <= B[WIDTH-1];
    end else if (last_bit) begin
      ovf_q <= (sign_a_q != sign_b_q) && (bit_d != sign_a_q);
    end
  end

  assign Ovf = ovf_q;
`endif

endmodule

// File: tb/tb_fs_serial_sub.sv
// Directed self-checking bench for fs_serial_sub (WIDTH=5): reset, basic,
// underflow, signed overflow, handshake, mid-run reset and all operand pairs.
module tb_fs_serial_sub;

  localparam int W       = 5;
  localparam int TIMEOUT = 20;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] A, B;
  logic         busy, done;
  logic [W-1:0] D;
  logic         Bout;
`ifdef FS_OVF_EN
  logic         Ovf;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  fs_serial_sub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .D     (D),
    .Bout  (Bout)
`ifdef FS_OVF_EN
    ,
    .Ovf   (Ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present an operation for one cycle; returns at the negedge after it was sampled.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts negedges until done is seen; cycles = -1 on timeout.
  task automatic wait_done(output int cycles, output int busy_cycles);
    cycles = 0;
    busy_cycles = 0;
    while (done !== 1'b1 && cycles < TIMEOUT) begin
      if (busy === 1'b1) busy_cycles++;
      @(negedge clk);
      cycles++;
    end
    if (done !== 1'b1) cycles = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0;
    #12;
    tests_run++;
    if ({busy, done, D, Bout} !== {1'b0, 1'b0, 5'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_outputs: busy=%b done=%b D=%0d Bout=%b, expected all 0", busy, done, D, Bout);
    end
`ifdef FS_OVF_EN
    tests_run++;
    if (Ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ovf: Ovf=%b, expected 0", Ovf);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int cyc, bcyc;
    start_op(5'd9, 5'd3);
    wait_done(cyc, bcyc);
    tests_run++;
    if (cyc !== 5) begin
      tests_failed++;
      $display("FAIL basic_latency: done after %0d cycles, expected 5", cyc);
    end
    tests_run++;
    if (bcyc !== 5) begin
      tests_failed++;
      $display("FAIL basic_busy: busy high %0d cycles, expected 5", bcyc);
    end
    tests_run++;
    if ({D, Bout} !== {5'd6, 1'b0}) begin
      tests_failed++;
      $display("FAIL basic_result: D=%0d Bout=%b, expected D=6 Bout=0", D, Bout);
    end
`ifdef FS_OVF_EN
    tests_run++;
    if (Ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_ovf: Ovf=%b, expected 0", Ovf);
    end
`endif
    @(negedge clk);
    tests_run++;
    if ({done, busy, D, Bout} !== {1'b0, 1'b0, 5'd6, 1'b0}) begin
      tests_failed++;
      $display("FAIL basic_pulse_hold: done=%b busy=%b D=%0d Bout=%b, expected 0 0 6 0", done, busy, D, Bout);
    end
  endtask

  task automatic test_underflow();
    int cyc, bcyc;
    start_op(5'd3, 5'd9);
    wait_done(cyc, bcyc);
    tests_run++;
    if ({cyc == 5, D, Bout} !== {1'b1, 5'h1A, 1'b1}) begin
      tests_failed++;
      $display("FAIL underflow_3_9: cycles=%0d D=%0d Bout=%b, expected cycles=5 D=26 Bout=1", cyc, D, Bout);
    end
`ifdef FS_OVF_EN
    tests_run++;
    if (Ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL underflow_3_9_ovf: Ovf=%b, expected 0", Ovf);
    end
`endif
    start_op(5'd0, 5'd31);
    wait_done(cyc, bcyc);
    tests_run++;
    if ({cyc == 5, D, Bout} !== {1'b1, 5'd1, 1'b1}) begin
      tests_failed++;
      $display("FAIL underflow_0_31: cycles=%0d D=%0d Bout=%b, expected cycles=5 D=1 Bout=1", cyc, D, Bout);
    end
  endtask

`ifdef FS_OVF_EN
  task automatic test_overflow();
    int cyc, bcyc;
    start_op(5'd15, 5'd16);
    wait_done(cyc, bcyc);
    tests_run++;
    if ({cyc == 5, D, Bout, Ovf} !== {1'b1, 5'd31, 1'b1, 1'b1}) begin
      tests_failed++;
      $display("FAIL ovf_15_16: cycles=%0d D=%0d Bout=%b Ovf=%b, expected 5 31 1 1", cyc, D, Bout, Ovf);
    end
    start_op(5'd16, 5'd1);
    wait_done(cyc, bcyc);
    tests_run++;
    if ({cyc == 5, D, Bout, Ovf} !== {1'b1, 5'd15, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL ovf_16_1: cycles=%0d D=%0d Bout=%b Ovf=%b, expected 5 15 0 1", cyc, D, Bout, Ovf);
    end
  endtask
`endif

  task automatic test_handshake();
    int cyc, bcyc;
    logic held_ok;
    start_op(5'd9, 5'd3);
    // Pulse start with different operands in RUN cycles 2 and 3.
    @(negedge clk);
    A = 5'd31; B = 5'd31; start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, bcyc);
    tests_run++;
    if ({cyc == 2, D, Bout} !== {1'b1, 5'd6, 1'b0}) begin
      tests_failed++;
      $display("FAIL handshake_ignore: cycles_left=%0d D=%0d Bout=%b, expected 2 6 0", cyc, D, Bout);
    end
    // start asserted during DONE starts the next op back-to-back.
    A = 5'd7; B = 5'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tests_run++;
    if ({busy, done} !== 2'b10) begin
      tests_failed++;
      $display("FAIL handshake_b2b_start: busy=%b done=%b, expected busy=1 done=0", busy, done);
    end
    held_ok = 1'b1;
    cyc = 0;
    while (done !== 1'b1 && cyc < TIMEOUT) begin
      if (D !== 5'd6) held_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    tests_run++;
    if (held_ok !== 1'b1) begin
      tests_failed++;
      $display("FAIL handshake_hold: D changed before completion, expected D=6 held");
    end
    tests_run++;
    if ({cyc == 5, D, Bout} !== {1'b1, 5'd5, 1'b0}) begin
      tests_failed++;
      $display("FAIL handshake_b2b_result: cycles=%0d D=%0d Bout=%b, expected 5 5 0", cyc, D, Bout);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, bcyc, dones;
    start_op(5'd9, 5'd3);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({busy, done, D, Bout} !== {1'b0, 1'b0, 5'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_mid_clear: busy=%b done=%b D=%0d Bout=%b, expected all 0", busy, done, D, Bout);
    end
`ifdef FS_OVF_EN
    tests_run++;
    if (Ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_ovf: Ovf=%b, expected 0", Ovf);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    tests_run++;
    if (dones !== 0) begin
      tests_failed++;
      $display("FAIL reset_mid_no_done: %0d cycles with busy/done after reset, expected 0", dones);
    end
    start_op(5'd20, 5'd20);
    wait_done(cyc, bcyc);
    tests_run++;
    if ({cyc == 5, D, Bout} !== {1'b1, 5'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_mid_equal: cycles=%0d D=%0d Bout=%b, expected 5 0 0", cyc, D, Bout);
    end
  endtask

  task automatic test_exhaustive();
    int cyc, bcyc;
    logic [W-1:0] ea, eb, exp_d;
    logic         exp_b;
    @(negedge clk);
    A = 5'd0; B = 5'd0; start = 1'b1;
    for (int idx = 0; idx < 1024; idx++) begin
      ea = A;
      eb = B;
      @(negedge clk);
      start = 1'b0;
      wait_done(cyc, bcyc);
      exp_d = ea - eb;
      exp_b = (ea < eb);
      tests_run++;
      if ({cyc == 5, D, Bout} !== {1'b1, exp_d, exp_b}) begin
        tests_failed++;
        $display("FAIL exhaustive A=%0d B=%0d: cycles=%0d D=%0d Bout=%b, expected 5 %0d %b",
                 ea, eb, cyc, D, Bout, exp_d, exp_b);
      end
`ifdef FS_OVF_EN
      tests_run++;
      if (Ovf !== ((ea[W-1] != eb[W-1]) && (exp_d[W-1] != ea[W-1]))) begin
        tests_failed++;
        $display("FAIL exhaustive_ovf A=%0d B=%0d: Ovf=%b", ea, eb, Ovf);
      end
`endif
      if (cyc < 0) break;
      if (idx < 1023) begin
        A = W'((idx + 1) / 32);
        B = W'((idx + 1) % 32);
        start = 1'b1;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underflow();
`ifdef FS_OVF_EN
    test_overflow();
`endif
    test_handshake();
    test_reset_mid();
    test_exhaustive();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fs_serial_sub.md
Name: fs_serial_sub

Overview:
- Bit-serial subtractor: computes A − B, one bit per clock, LSB first.
- Uses a single full-subtractor cell, with a start/done handshake.
- Subtraction counterpart to the ripple-carry adders in the computation unit; trades latency for area.
- Result, borrow-out and (optionally) signed overflow are held until the next operation.

Parameters:
- WIDTH, 5, operand and result width in bits (≥2).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when idle or done
- A  input  WIDTH  minuend; sampled with start
- B  input  WIDTH  subtrahend; sampled with start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse; result valid
- D  output  WIDTH  difference A − B mod 2^WIDTH
- Bout  output  1  final borrow (1 when A < B unsigned)
- Ovf  output  1  signed overflow (only with FS_OVF_EN)

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low. While rst_n=0: state=IDLE, busy=0, done=0, D=0, Bout=0, Ovf=0, bit counter=0, internal borrow=0.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge t0:
  - latch A, B into shift registers;
  - clear borrow and counter;
  - go to RUN; busy=1 from t0.
- RUN, each edge:
  - fs cell computes d = a_i ^ b_i ^ bin and bo = (~a_i & b_i) | (~(a_i ^ b_i) & bin);
  - d shifts into the MSB of the result register (right shift);
  - operand registers shift right; borrow register ← bo; counter increments.
- Exit from RUN: after edge t0+WIDTH (counter reaches WIDTH−1 → last bit):
  - state=DONE, busy=0, done=1;
  - D = full result; Bout = final bo.
- DONE lasts exactly one cycle; done=1 only in DONE.
  - start=1 in DONE: accepted as in IDLE (back-to-back; next done at t0'+WIDTH).
  - Otherwise go to IDLE.
- Latency: done asserted exactly WIDTH cycles after start is sampled. Throughput: one result per WIDTH cycles.
- Output hold: D, Bout and Ovf are updated only on the transition into DONE and held until the next completion. Partial results never appear on D; a separate shift register is copied to D at completion.
- start while RUN: ignored. A and B changes during RUN: no effect.
- Reset mid-operation: aborts immediately, all outputs cleared; no done pulse.
- Boundaries:
  - A=B gives D=0, Bout=0.
  - A=0, B=2^WIDTH−1 gives D=1, Bout=1.

Optional Feature:
- Macro FS_OVF_EN.
- Defined:
  - MSB of A and B is captured at start;
  - at completion, Ovf = (A[MSB] ≠ B[MSB]) & (D[MSB] ≠ A[MSB]);
  - Ovf follows the same reset, update and hold rules as D.
- Undefined: Ovf port is absent; no sign capture logic.

Decomposition:
- Shared package fs_pkg:
  - state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - counter-width function clog2(WIDTH).
- One sub-module, fs: combinational 1-bit full subtractor (bin, a, b → bo, d). It mirrors the existing full-adder cell and is instantiated once.

Test Plan (WIDTH=5):
- Basic: A=9, B=3, start one cycle → done exactly 5 cycles later; D=6, Bout=0, Ovf=0; busy high for 5 cycles.
- Underflow: A=3, B=9 → D=26 (5'h1A), Bout=1, Ovf=0. Then A=0, B=31 → D=1, Bout=1.
- Signed overflow (FS_OVF_EN): A=15, B=16 (−16) → D=31, Bout=1, Ovf=1. A=16, B=1 → D=15, Ovf=1, Bout=0.
- Handshake: start pulsed at cycles 2 and 3 of RUN with A=31, B=31 → ignored, first result unchanged. start held in DONE → second op begins; its done comes 5 cycles later; D holds the first result until then.
- Reset: rst_n=0 asynchronously during cycle 3 of RUN → all outputs 0 immediately; no done. After release, A=20, B=20 → D=0, Bout=0.
- Exhaustive: all 1024 (A,B) pairs back-to-back → D = (A−B) mod 32, Bout = (A<B), Ovf per signed rule; checked against a reference model.
